// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and code helpers for the iterative multiplier
`ifndef ALU_CODES_SV
`include "alu_codes.sv"
`endif

package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    localparam logic [3:0] FADD    = `FADD;
    localparam logic [3:0] FMULT   = `FMULT;
    localparam logic [3:0] FMULTH  = `FMULTH;
    localparam logic [3:0] FMULTHU = `FMULTHU;

    // Codes this unit actually computes; anything else completes with err set
    function automatic logic is_mult_code(input logic [3:0] f);
        return (f == FMULT) || (f == FMULTH) || (f == FMULTHU);
    endfunction

    // Signed codes multiply magnitudes and fix the sign afterwards
    function automatic logic is_signed_code(input logic [3:0] f);
        return (f == FMULT) || (f == FMULTH);
    endfunction

endpackage

// File: rtl/alu_codes.sv
// rtl/alu_codes.sv - shared ALU function codes
`ifndef ALU_CODES_SV
`define ALU_CODES_SV

`define FADD    4'h0
`define FSUB    4'h1
`define FAND    4'h2
`define FOR     4'h3
`define FXOR    4'h4
`define FSLL    4'h5
`define FSRL    4'h6
`define FSRA    4'h7
`define FSLT    4'h8
`define FSLTU   4'h9
`define FMULT   4'hA
`define FMULTH  4'hB
`define FMULTHU 4'hC

`endif

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - radix-2 shift-add multiply responder with start/done handshake
module mult_unit
    import mult_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clock,
    input  logic         nReset,
    input  logic         start,
    input  logic [3:0]   func,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result,
    output logic         err
);

    localparam int CW = $clog2(n + 1);

    mult_state_t     state;
    mult_state_t     state_next;
    logic [CW-1:0]   cnt;
    logic [2*n-1:0]  acc;
    logic [n-1:0]    mcand;
    logic [n-1:0]    mplr;
    logic [3:0]      func_q;
    logic            sign_q;

    logic            accept;
    logic            last_iter;
    logic [n-1:0]    abs_a;
    logic [n-1:0]    abs_b;
    logic [n:0]      addend;
    logic [n:0]      sum;
    logic [2*n-1:0]  fixed;
    logic [n-1:0]    selected;

    // A request is taken only when nothing is in flight
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (cnt == CW'(n - 1));

    // Operand magnitudes; the most-negative value maps to 2^(n-1) unchanged
    assign abs_a = a[n-1] ? (~a + n'(1)) : a;
    assign abs_b = b[n-1] ? (~b + n'(1)) : b;

    // One shift-add step: add into the upper half with a carry bit
    assign addend = mplr[0] ? {1'b0, mcand} : '0;
    assign sum    = {1'b0, acc[2*n-1:n]} + addend;

    // Sign fix-up over the whole 2n-bit product, modulo 2^(2n)
    assign fixed = sign_q ? (~acc + (2*n)'(1)) : acc;

    // Half selection by the latched code; unsupported codes return zero
    always_comb begin
        selected = '0;
        if (func_q == FMULT) begin
            selected = fixed[n-1:0];
        end else if ((func_q == FMULTH) || (func_q == FMULTHU)) begin
            selected = fixed[2*n-1:n];
        end
    end

    // State register
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; unsupported codes skip the iteration loop
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = is_mult_code(func) ? CALC : FIX;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (start) begin
                    state_next = is_mult_code(func) ? CALC : FIX;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, iterate in CALC, finalise in FIX
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            func_q <= '0;
            sign_q <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            if (accept) begin
                func_q <= func;
                acc    <= '0;
                cnt    <= '0;
                if (is_signed_code(func)) begin
                    mcand  <= abs_a;
                    mplr   <= abs_b;
                    sign_q <= a[n-1] ^ b[n-1];
                end else begin
                    mcand  <= a;
                    mplr   <= b;
                    sign_q <= 1'b0;
                end
            end else if (state == CALC) begin
                acc  <= {sum, acc[n-1:1]};
                mplr <= {1'b0, mplr[n-1:1]};
                cnt  <= cnt + CW'(1);
            end else if (state == FIX) begin
                acc    <= fixed;
                result <= selected;
                err    <= ~is_mult_code(func_q);
            end
        end
    end

    // Handshake outputs decoded straight from state
    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

endmodule
